// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
// Two-requester round-robin arbiter in front of a single-port synchronous RAM
// running in bypass mode (read data appears one cycle after the RAM samples
// the read).
//
// Every access has a fixed latency of 2 cycles:
//   T   : grant.
//         The RAM controls are driven combinationally from the winner.
//   T+1 : stage 1 holds {valid, id, wr}.
//         ram_dout is valid for reads.
//   T+2 : the response register of the requester is valid.
//         It holds until that requester's rsp ready.
//
// A requester with an access in flight, or with an unconsumed response, is
// not eligible. Each response register can therefore only be written while it
// is empty.
//
// Ports
//   clk, resetn          : clock and synchronous active-low reset
//   reqN_*  (N = 0, 1)   : valid/ready request channel with wr, addr, wdata
//                          and wstrb
//   rspN_*  (N = 0, 1)   : valid/ready response channel with rdata and wr
//                          (rdata is 0 for write acks)
//   ram_*                : single-port RAM macro interface
// -----------------------------------------------------------------------------
module sp_ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_wr,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_wdata,
    input  logic [DW/8-1:0] req0_wstrb,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [DW-1:0]   rsp0_rdata,
    output logic            rsp0_wr,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_wr,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_wdata,
    input  logic [DW/8-1:0] req1_wstrb,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [DW-1:0]   rsp1_rdata,
    output logic            rsp1_wr,

    output logic            ram_ce,
    output logic            ram_oce,
    output logic            ram_reset,
    output logic            ram_wre,
    output logic [AW-1:0]   ram_ad,
    output logic [DW-1:0]   ram_din,
    output logic [DW/8-1:0] ram_byte_en,
    input  logic [DW-1:0]   ram_dout
);

    localparam int BW = DW / 8;

    // Stage 1: the access whose read data is on ram_dout this cycle.
    logic            s1_valid_q, s1_valid_d;
    logic            s1_id_q,    s1_id_d;
    logic            s1_wr_q,    s1_wr_d;

    // Round-robin pointer.
    // It holds the id of the requester granted most recently.
    logic            last_q, last_d;

    // Response holding registers.
    logic            rsp0_valid_q, rsp0_valid_d;
    logic [DW-1:0]   rsp0_rdata_q, rsp0_rdata_d;
    logic            rsp0_wr_q,    rsp0_wr_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0]   rsp1_rdata_q, rsp1_rdata_d;
    logic            rsp1_wr_q,    rsp1_wr_d;

    logic            elig0_s, elig1_s;
    logic            ready0_s, ready1_s;
    logic            gnt0_s, gnt1_s, gnt_any_s;
    logic [DW-1:0]   cap_data_s;

    // Eligibility, ready generation and grant decode.
    always_comb begin
        elig0_s = resetn & ~rsp0_valid_q & ~(s1_valid_q & (s1_id_q == 1'b0));
        elig1_s = resetn & ~rsp1_valid_q & ~(s1_valid_q & (s1_id_q == 1'b1));
        // A requester loses only when the other one contends and was not
        // served most recently.
        // Both ready signals cannot be 1 while both requesters are valid.
        ready0_s  = elig0_s & ~(req1_valid & elig1_s & (last_q == 1'b0));
        ready1_s  = elig1_s & ~(req0_valid & elig0_s & (last_q == 1'b1));
        gnt0_s    = req0_valid & ready0_s;
        gnt1_s    = req1_valid & ready1_s;
        gnt_any_s = gnt0_s | gnt1_s;
    end

    // RAM command mux.
    // The bus is forced to all zeros when there is no grant.
    always_comb begin
        ram_ce      = 1'b0;
        ram_wre     = 1'b0;
        ram_ad      = '0;
        ram_din     = '0;
        ram_byte_en = '0;
        if (gnt0_s) begin
            ram_ce      = 1'b1;
            ram_wre     = req0_wr;
            ram_ad      = req0_addr;
            ram_din     = req0_wdata;
            ram_byte_en = req0_wr ? req0_wstrb : {BW{1'b1}};
        end else if (gnt1_s) begin
            ram_ce      = 1'b1;
            ram_wre     = req1_wr;
            ram_ad      = req1_addr;
            ram_din     = req1_wdata;
            ram_byte_en = req1_wr ? req1_wstrb : {BW{1'b1}};
        end else begin
            ram_ce      = 1'b0;
        end
    end

    // Next state for stage 1, the pointer and both response registers.
    always_comb begin
        s1_valid_d   = gnt_any_s;
        s1_id_d      = gnt1_s;
        s1_wr_d      = gnt1_s ? req1_wr : req0_wr;
        last_d       = gnt_any_s ? gnt1_s : last_q;
        cap_data_s   = s1_wr_q ? '0 : ram_dout;

        rsp0_valid_d = rsp0_valid_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp0_wr_d    = rsp0_wr_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp1_wr_d    = rsp1_wr_q;

        // Consume and capture never coincide for one requester.
        // A full response register blocks any new grant to that requester.
        if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end else if (s1_valid_q && (s1_id_q == 1'b0)) begin
            rsp0_valid_d = 1'b1;
            rsp0_rdata_d = cap_data_s;
            rsp0_wr_d    = s1_wr_q;
        end else begin
            rsp0_valid_d = rsp0_valid_q;
        end

        if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end else if (s1_valid_q && (s1_id_q == 1'b1)) begin
            rsp1_valid_d = 1'b1;
            rsp1_rdata_d = cap_data_s;
            rsp1_wr_d    = s1_wr_q;
        end else begin
            rsp1_valid_d = rsp1_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    // On reset, last_q is set to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_wr_q      <= 1'b0;
            last_q       <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp0_wr_q    <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_rdata_q <= '0;
            rsp1_wr_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_wr_q      <= s1_wr_d;
            last_q       <= last_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp0_wr_q    <= rsp0_wr_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp1_wr_q    <= rsp1_wr_d;
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp0_wr    = rsp0_wr_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp1_wr    = rsp1_wr_q;
    assign ram_oce    = 1'b1;
    assign ram_reset  = ~resetn;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_arbiter
// Directed bench for sp_ram_arbiter with a behavioural bypass-mode RAM.
//
// At every grant, a negedge monitor predicts the response from a shadow copy
// of the memory and queues it. The prediction covers the data, the wr flag and
// the cycle the response is due. The monitor then compares each response
// against the head of its queue.
// -----------------------------------------------------------------------------
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req0_wr;
    logic [7:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_wstrb;
    logic        rsp0_valid, rsp0_ready, rsp0_wr;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_wr;
    logic [7:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_wstrb;
    logic        rsp1_valid, rsp1_ready, rsp1_wr;
    logic [31:0] rsp1_rdata;
    logic        ram_ce, ram_oce, ram_reset, ram_wre;
    logic [7:0]  ram_ad;
    logic [31:0] ram_din;
    logic [3:0]  ram_byte_en;
    logic [31:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          glog[$];
    int          gcyc[$];
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    logic        prev0 = 1'b0;
    logic        prev1 = 1'b0;

    sp_ram_arbiter #(.AW(8), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_rdata(rsp0_rdata), .rsp0_wr(rsp0_wr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_rdata(rsp1_rdata), .rsp1_wr(rsp1_wr),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset),
        .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_byte_en(ram_byte_en), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Cycle counter, stepped on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM, bypass mode.
    always @(posedge clk) begin
        if (ram_reset) begin
            ram_dout <= 32'h0;
        end else if (ram_ce) begin
            if (ram_wre) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byte_en[b]) mem[ram_ad][8*b +: 8] = ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input int id, input logic v, input logic r,
                             input logic [31:0] d, input logic w, input logic pv);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            if (v) chk($sformatf("rsp%0d_unexpected", id), {63'd0, v}, 64'd0);
        end else begin
            e = (id == 0) ? q0[0] : q1[0];
            if (v) begin
                chk($sformatf("rsp%0d_data", id), {32'd0, d}, {32'd0, e.data});
                chk($sformatf("rsp%0d_wr", id), {63'd0, w}, {63'd0, e.wr});
                if (!pv) chk($sformatf("rsp%0d_latency", id), 64'(cyc), 64'(e.due));
                if (r) begin
                    if (id == 0) void'(q0.pop_front());
                    else         void'(q1.pop_front());
                end
            end else if (cyc >= e.due) begin
                chk($sformatf("rsp%0d_missing", id), {63'd0, v}, 64'd1);
            end
        end
    endtask

    // Monitor: checks the RAM bus and the grants, and runs the response scoreboard.
    always @(negedge clk) begin
        logic g0, g1, wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        exp_t        e;
        if (!resetn) begin
            chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
            chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
            chk("rst_ram_ce", {63'd0, ram_ce}, 64'd0);
            chk("rst_ram_reset", {63'd0, ram_reset}, 64'd1);
            q0.delete();
            q1.delete();
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            g0 = req0_valid & req0_ready;
            g1 = req1_valid & req1_ready;
            chk("one_grant", {63'd0, g0 & g1}, 64'd0);
            chk("ram_ce", {63'd0, ram_ce}, {63'd0, g0 | g1});
            if (g0 | g1) begin
                wr = g0 ? req0_wr    : req1_wr;
                a  = g0 ? req0_addr  : req1_addr;
                d  = g0 ? req0_wdata : req1_wdata;
                s  = g0 ? req0_wstrb : req1_wstrb;
                chk("ram_cmd", {19'd0, ram_wre, ram_ad, ram_din, ram_byte_en},
                    {19'd0, wr, a, d, (wr ? s : 4'hF)});
                e.wr   = wr;
                e.data = wr ? 32'h0 : shadow[a];
                e.due  = cyc + 2;
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
                end
                if (g0) q0.push_back(e);
                else    q1.push_back(e);
                glog.push_back(g0 ? 0 : 1);
                gcyc.push_back(cyc);
            end else begin
                chk("ram_idle", {19'd0, ram_wre, ram_ad, ram_din, ram_byte_en}, 64'd0);
            end
            check_rsp(0, rsp0_valid, rsp0_ready, rsp0_rdata, rsp0_wr, prev0);
            check_rsp(1, rsp1_valid, rsp1_ready, rsp1_rdata, rsp1_wr, prev1);
            prev0 = rsp0_valid;
            prev1 = rsp1_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int id, input logic wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        if (id == 0) begin
            req0_valid = 1'b1; req0_wr = wr; req0_addr = a; req0_wdata = d; req0_wstrb = s;
        end else begin
            req1_valid = 1'b1; req1_wr = wr; req1_addr = a; req1_wdata = d; req1_wstrb = s;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) done = 1'b1;
            tick();
        end
        if (!done) chk($sformatf("grant_timeout%0d", id), 64'd0, 64'd1);
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int id, output logic [31:0] data);
        bit got = 1'b0;
        data = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id == 0) ? rsp0_valid : rsp1_valid) begin
                got  = 1'b1;
                data = (id == 0) ? rsp0_rdata : rsp1_rdata;
            end
            tick();
        end
        if (!got) chk($sformatf("rsp_timeout%0d", id), 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        bit          served0;
        bit          got1;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA5000000 | i;
            shadow[i] = 32'hA5000000 | i;
        end
        resetn = 1'b0;
        req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = 8'h0; req0_wdata = 32'h0; req0_wstrb = 4'h0;
        req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = 8'h0; req1_wdata = 32'h0; req1_wstrb = 4'h0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // Reset state.
        tick(); tick();
        @(negedge clk);
        chk("rst_rsp_state", {30'd0, rsp0_valid, rsp0_wr, rsp1_valid, rsp1_wr},  64'd0);
        chk("rst_rdata",     {rsp0_rdata, rsp1_rdata}, 64'd0);
        chk("ram_oce",       {63'd0, ram_oce}, 64'd1);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("ram_reset_rel", {63'd0, ram_reset}, 64'd0);
        tick();

        // Write, then read back, on requester 0.
        do_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        wait_rsp(0, d);
        chk("wr_ack_data", {32'd0, d}, 64'd0);
        do_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
        wait_rsp(0, d);
        chk("rd_deadbeef", {32'd0, d}, 64'hDEADBEEF);

        // Byte-strobe merge, plus a zero-strobe write, on requester 1.
        do_req(1, 1'b1, 8'h20, 32'h11223344, 4'hF);
        wait_rsp(1, d);
        do_req(1, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5);
        wait_rsp(1, d);
        do_req(1, 1'b0, 8'h20, 32'h0, 4'h0);
        wait_rsp(1, d);
        chk("rd_merge", {32'd0, d}, 64'h11BB33DD);
        do_req(1, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0);
        wait_rsp(1, d);
        do_req(1, 1'b0, 8'h20, 32'h0, 4'h0);
        wait_rsp(1, d);
        chk("rd_after_wstrb0", {32'd0, d}, 64'h11BB33DD);

        // Both requesters continuously valid.
        glog.delete();
        gcyc.delete();
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h01;
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h02;
        repeat (13) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) tick();
        chk("rr_grant_count", {63'd0, glog.size() >= 8}, 64'd1);
        for (int i = 1; i < glog.size(); i++)
            chk("rr_alternate", 64'(glog[i] != glog[i-1]), 64'd1);
        for (int i = 2; i < gcyc.size(); i++)
            chk("rr_same_req_gap", 64'(gcyc[i] - gcyc[i-2]), 64'd3);

        // A response on requester 1 is held back while requester 0 keeps running.
        rsp1_ready = 1'b0;
        do_req(1, 1'b0, 8'h20, 32'h0, 4'h0);
        wait_rsp(1, d);
        chk("held_first", {32'd0, d}, 64'h11BB33DD);
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h02;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h10;
        served0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_req1_ready", {63'd0, req1_ready}, 64'd0);
            chk("held_rsp1", {31'd0, rsp1_valid, rsp1_rdata}, {31'd0, 1'b1, 32'h11BB33DD});
            if (req0_valid && req0_ready) served0 = 1'b1;
            tick();
            if (served0) req0_valid = 1'b0;
        end
        chk("held_req0_served", {63'd0, served0}, 64'd1);
        rsp1_ready = 1'b1;
        got1 = 1'b0;
        for (int i = 0; i < 10 && !got1; i++) begin
            @(negedge clk);
            if (req1_ready) got1 = 1'b1;
            tick();
        end
        chk("held_req1_regrant", {63'd0, got1}, 64'd1);
        req1_valid = 1'b0;
        repeat (4) tick();

        // Reset in the cycle after a grant.
        do_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
        resetn = 1'b0;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h01;
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h02;
        tick(); tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {62'd0, req0_ready, req1_ready}, 64'd2);
        chk("post_rst_rsp",   {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp2", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        tick();
        req1_valid = 1'b0;
        repeat (6) tick();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
